// File: rtl/ext_bus_pkg.sv
// Shared types and timing defaults for the external parallel bus initiator.
package ext_bus_pkg;

  localparam int CNT_W          = 8;
  localparam int DEF_DATA_W     = 16;
  localparam int DEF_SETUP_CYC  = 2;
  localparam int DEF_TURN_CYC   = 2;
  localparam int DEF_STROBE_CYC = 4;
  localparam int DEF_HOLD_CYC   = 2;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SETUP     = 3'd1,
    ST_WR_TURN   = 3'd2,
    ST_WR_DRIVE  = 3'd3,
    ST_WR_HOLD   = 3'd4,
    ST_RD_STROBE = 3'd5,
    ST_RECOVER   = 3'd6
  } state_e;

  // A phase of n cycles loads n-1 so the zero flag marks its final cycle.
  function automatic logic [CNT_W-1:0] cyc_load(input int unsigned n);
    cyc_load = CNT_W'(n - 32'd1);
  endfunction

endpackage

// File: rtl/ext_bus_timer.sv
// Loadable down-counter that saturates at zero; zero_o flags the last cycle of a phase.
module ext_bus_timer
  import ext_bus_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: load takes priority, otherwise count down to zero and stay there.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != '0) begin
      count_d = count_q - CNT_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Counter register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/ext_bus_master.sv
// Initiator for the async CE/OE/WE parallel bus: turns single-word requests into
// timed bus cycles with fully registered bus outputs.
module ext_bus_master
  import ext_bus_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int SETUP_CYC  = DEF_SETUP_CYC,
  parameter int TURN_CYC   = DEF_TURN_CYC,
  parameter int STROBE_CYC = DEF_STROBE_CYC,
  parameter int HOLD_CYC   = DEF_HOLD_CYC
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              bus_ce_n,
  output logic              bus_oe_n,
  output logic              bus_we_n,
  output logic [DATA_W-1:0] bus_d_out,
  output logic              bus_d_oe,
  input  logic [DATA_W-1:0] bus_d_in
);

  state_e            state_q;
  logic              ready_q;
  logic              write_q;
  logic [DATA_W-1:0] wdata_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              ce_n_q;
  logic              oe_n_q;
  logic              we_n_q;
  logic [DATA_W-1:0] d_out_q;
  logic              d_oe_q;

  logic              accept_s;
  logic              zero_s;
  logic              load_s;
  logic [CNT_W-1:0]  load_val_s;

  assign accept_s = req_valid & ready_q;
  assign load_s   = (state_q == ST_IDLE) ? accept_s : zero_s;

  // Phase length of the state being entered on the next transition.
  always_comb begin
    load_val_s = '0;
    case (state_q)
      ST_IDLE:                  load_val_s = cyc_load(SETUP_CYC);
      ST_SETUP:                 load_val_s = write_q ? cyc_load(TURN_CYC) : cyc_load(STROBE_CYC);
      ST_WR_TURN:               load_val_s = cyc_load(STROBE_CYC);
      ST_WR_DRIVE:              load_val_s = cyc_load(HOLD_CYC);
      ST_WR_HOLD, ST_RD_STROBE: load_val_s = cyc_load(TURN_CYC);
      default:                  load_val_s = '0;
    endcase
  end

  ext_bus_timer u_timer (
    .clock      (clock),
    .reset_n    (reset_n),
    .load_i     (load_s),
    .load_val_i (load_val_s),
    .zero_o     (zero_s)
  );

  // Bus cycle sequencer; every bus output changes only on a state transition.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      ready_q     <= 1'b1;
      write_q     <= 1'b0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      d_out_q     <= '0;
      d_oe_q      <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept_s) begin
            write_q <= req_write;
            wdata_q <= req_wdata;
            ready_q <= 1'b0;
            ce_n_q  <= 1'b0;
            state_q <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (zero_s) begin
            if (write_q) begin
              we_n_q  <= 1'b0;
              state_q <= ST_WR_TURN;
            end else begin
              oe_n_q  <= 1'b0;
              state_q <= ST_RD_STROBE;
            end
          end
        end
        // WE is already low here so the responder has released the data lines.
        ST_WR_TURN: begin
          if (zero_s) begin
            d_oe_q  <= 1'b1;
            d_out_q <= wdata_q;
            state_q <= ST_WR_DRIVE;
          end
        end
        ST_WR_DRIVE: begin
          if (zero_s) begin
            we_n_q  <= 1'b1;
            state_q <= ST_WR_HOLD;
          end
        end
        ST_WR_HOLD: begin
          if (zero_s) begin
            ce_n_q      <= 1'b1;
            d_oe_q      <= 1'b0;
            d_out_q     <= '0;
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RECOVER;
          end
        end
        ST_RD_STROBE: begin
          if (zero_s) begin
            rsp_rdata_q <= bus_d_in;
            oe_n_q      <= 1'b1;
            ce_n_q      <= 1'b1;
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RECOVER;
          end
        end
        ST_RECOVER: begin
          if (zero_s) begin
            ready_q <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          ce_n_q  <= 1'b1;
          oe_n_q  <= 1'b1;
          we_n_q  <= 1'b1;
          d_oe_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign bus_ce_n  = ce_n_q;
  assign bus_oe_n  = oe_n_q;
  assign bus_we_n  = we_n_q;
  assign bus_d_out = d_out_q;
  assign bus_d_oe  = d_oe_q;

endmodule

// File: tb/tb_ext_bus_master.sv
// Directed bench for ext_bus_master with cycle-exact timing checks and an SRAM-style loopback responder.
module tb_ext_bus_master;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [15:0] req_wdata = 16'h0000;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        bus_ce_n;
  logic        bus_oe_n;
  logic        bus_we_n;
  logic [15:0] bus_d_out;
  logic        bus_d_oe;
  logic [15:0] bus_d_in;

  logic        use_resp = 1'b0;
  logic [15:0] tb_din = 16'h0000;

  // Behavioural responder: 2-flop synchronisers on WE/OE, edge detect between stages.
  logic        r_we1 = 1'b1, r_we2 = 1'b1, r_oe1 = 1'b1, r_oe2 = 1'b1;
  logic        r_drive = 1'b0;
  logic [15:0] r_mem = 16'h0000;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  always @(posedge clock) begin
    r_we1 <= bus_we_n;
    r_we2 <= r_we1;
    r_oe1 <= bus_oe_n;
    r_oe2 <= r_oe1;
    if (r_we2 && !r_we1) r_drive <= 1'b0;
    else if (r_oe2 && !r_oe1) r_drive <= 1'b1;
    if (r_we1 && !r_we2) r_mem <= bus_d_out;
  end

  assign bus_d_in = use_resp ? (r_drive ? r_mem : 16'h0000) : tb_din;

  ext_bus_master dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .bus_ce_n  (bus_ce_n),
    .bus_oe_n  (bus_oe_n),
    .bus_we_n  (bus_we_n),
    .bus_d_out (bus_d_out),
    .bus_d_oe  (bus_d_oe),
    .bus_d_in  (bus_d_in)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if ({bus_ce_n, bus_oe_n, bus_we_n, bus_d_oe, req_ready, rsp_valid} !== 6'b111010) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=%b", {bus_ce_n, bus_oe_n, bus_we_n, bus_d_oe, req_ready, rsp_valid}, 6'b111010);
    end
    checks++;
    if ({bus_d_out, rsp_rdata} !== 32'h0000_0000) begin
      failures++;
      $display("FAIL reset_data got=%h exp=%h", {bus_d_out, rsp_rdata}, 32'h0000_0000);
    end
    reset_n = 1'b1;
    repeat (3) step();
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({bus_ce_n, bus_oe_n, bus_we_n, bus_d_oe, req_ready, rsp_valid} !== 6'b111010) begin
      failures++;
      $display("FAIL reset_idle got=%b exp=%b", {bus_ce_n, bus_oe_n, bus_we_n, bus_d_oe, req_ready, rsp_valid}, 6'b111010);
    end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_write();
    logic e_ce, e_we, e_doe, e_rv, e_rdy;
    req_write = 1'b1;
    req_wdata = 16'hBEEF;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    for (int n = 1; n <= 14; n++) begin
      e_ce  = !(n <= 10);
      e_we  = !(n >= 3 && n <= 8);
      e_doe = (n >= 5 && n <= 10);
      e_rv  = (n == 11);
      e_rdy = (n >= 13);
      checks++;
      if ({bus_ce_n, bus_oe_n, bus_we_n, bus_d_oe, rsp_valid, req_ready} !== {e_ce, 1'b1, e_we, e_doe, e_rv, e_rdy}) begin
        failures++;
        $display("FAIL write_ctrl t+%0d got=%b exp=%b", n,
                 {bus_ce_n, bus_oe_n, bus_we_n, bus_d_oe, rsp_valid, req_ready}, {e_ce, 1'b1, e_we, e_doe, e_rv, e_rdy});
      end
      if (e_doe) begin
        checks++;
        if (bus_d_out !== 16'hBEEF) begin
          failures++;
          $display("FAIL write_data t+%0d got=%h exp=%h", n, bus_d_out, 16'hBEEF);
        end
      end
      step();
    end
  endtask

  task automatic test_read();
    logic e_ce, e_oe, e_rv, e_rdy;
    tb_din = 16'h0000;
    req_write = 1'b0;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      if (n == 4) tb_din = 16'h1234;
      e_ce  = !(n <= 6);
      e_oe  = !(n >= 3 && n <= 6);
      e_rv  = (n == 7);
      e_rdy = (n >= 9);
      checks++;
      if ({bus_ce_n, bus_oe_n, bus_we_n, bus_d_oe, rsp_valid, req_ready} !== {e_ce, e_oe, 1'b1, 1'b0, e_rv, e_rdy}) begin
        failures++;
        $display("FAIL read_ctrl t+%0d got=%b exp=%b", n,
                 {bus_ce_n, bus_oe_n, bus_we_n, bus_d_oe, rsp_valid, req_ready}, {e_ce, e_oe, 1'b1, 1'b0, e_rv, e_rdy});
      end
      if (n >= 7) begin
        checks++;
        if (rsp_rdata !== 16'h1234) begin
          failures++;
          $display("FAIL read_data t+%0d got=%h exp=%h", n, rsp_rdata, 16'h1234);
        end
      end
      if (n == 7) tb_din = 16'h5555;
      step();
    end
  endtask

  task automatic test_back_to_back();
    int first_rdy = 0, ce_falls = 0, oe_cnt = 0, first_oe = 0, rv_cnt = 0, rv_last = 0;
    logic prev_ce = 1'b1;
    req_write = 1'b1;
    req_wdata = 16'h0F0F;
    req_valid = 1'b1;
    step();
    req_write = 1'b0;
    for (int n = 1; n <= 24; n++) begin
      if (req_ready && first_rdy == 0) first_rdy = n;
      if (prev_ce && !bus_ce_n) ce_falls++;
      prev_ce = bus_ce_n;
      if (!bus_oe_n) begin
        oe_cnt++;
        if (first_oe == 0) first_oe = n;
      end
      if (rsp_valid) begin
        rv_cnt++;
        rv_last = n;
      end
      if (n >= 2 && n <= 11) req_valid = n[0];
      else if (n >= 14) req_valid = 1'b0;
      else req_valid = 1'b1;
      step();
    end
    checks++;
    if (first_rdy != 13) begin failures++; $display("FAIL b2b_ready got=%0d exp=%0d", first_rdy, 13); end
    checks++;
    if (ce_falls != 2) begin failures++; $display("FAIL b2b_ce_falls got=%0d exp=%0d", ce_falls, 2); end
    checks++;
    if (first_oe != 16) begin failures++; $display("FAIL b2b_first_oe got=%0d exp=%0d", first_oe, 16); end
    checks++;
    if (oe_cnt != 4) begin failures++; $display("FAIL b2b_oe_len got=%0d exp=%0d", oe_cnt, 4); end
    checks++;
    if (rv_cnt != 2 || rv_last != 20) begin
      failures++;
      $display("FAIL b2b_rsp got=%0d@%0d exp=%0d@%0d", rv_cnt, rv_last, 2, 20);
    end
  endtask

  task automatic test_reset_mid_write();
    int rv_seen = 0, ce_seen = 0;
    req_write = 1'b1;
    req_wdata = 16'h3C3C;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    repeat (5) step();
    checks++;
    if ({bus_we_n, bus_d_oe} !== 2'b01) begin
      failures++;
      $display("FAIL midrst_pre got=%b exp=%b", {bus_we_n, bus_d_oe}, 2'b01);
    end
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if ({bus_ce_n, bus_oe_n, bus_we_n, bus_d_oe, req_ready, rsp_valid} !== 6'b111010) begin
      failures++;
      $display("FAIL midrst_release got=%b exp=%b", {bus_ce_n, bus_oe_n, bus_we_n, bus_d_oe, req_ready, rsp_valid}, 6'b111010);
    end
    reset_n = 1'b1;
    for (int n = 0; n < 15; n++) begin
      step();
      if (rsp_valid) rv_seen++;
      if (!bus_ce_n) ce_seen++;
    end
    checks++;
    if (rv_seen != 0 || ce_seen != 0) begin
      failures++;
      $display("FAIL midrst_after got=rsp%0d/ce%0d exp=rsp0/ce0", rv_seen, ce_seen);
    end
  endtask

  task automatic test_loopback();
    logic done;
    use_resp = 1'b1;
    for (int k = 0; k < 2; k++) begin
      req_write = (k == 0);
      req_wdata = 16'hA5C3;
      req_valid = 1'b1;
      step();
      req_valid = 1'b0;
      done = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
        checks++;
        if (bus_d_oe && r_drive) begin
          failures++;
          $display("FAIL loop_contention k=%0d c=%0d got=%b exp=%b", k, c, {bus_d_oe, r_drive}, 2'b00);
        end
        if (rsp_valid) begin
          done = 1'b1;
          if (k == 1) begin
            checks++;
            if (rsp_rdata !== 16'hA5C3) begin
              failures++;
              $display("FAIL loop_rdata got=%h exp=%h", rsp_rdata, 16'hA5C3);
            end
          end
        end
        step();
      end
      checks++;
      if (!done) begin failures++; $display("FAIL loop_timeout k=%0d got=%b exp=%b", k, done, 1'b1); end
      for (int c = 0; c < 8 && !req_ready; c++) begin
        checks++;
        if (bus_d_oe && r_drive) begin
          failures++;
          $display("FAIL loop_contention_rec k=%0d got=%b exp=%b", k, {bus_d_oe, r_drive}, 2'b00);
        end
        step();
      end
      checks++;
      if (req_ready !== 1'b1) begin failures++; $display("FAIL loop_idle k=%0d got=%b exp=%b", k, req_ready, 1'b1); end
      if (k == 0) begin
        checks++;
        if (r_mem !== 16'hA5C3) begin failures++; $display("FAIL loop_mem got=%h exp=%h", r_mem, 16'hA5C3); end
      end
    end
    use_resp = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_reset_mid_write();
    test_loopback();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
